custom_ip_regbank: RTL and testbench

//  APB3-slave register bank driving the register side of the custom IP register interface.

---
 rtl/custom_ip_regbank_if.sv | 21 ++
 rtl/custom_ip_regbank.sv | 203 ++++++++++++++++++++
 tb/tb_custom_ip_regbank.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/custom_ip_regbank_if.sv
// APB3 bus bundle between the SoC peripheral bus and the custom IP register bank.
interface custom_ip_regbank_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [7:0]  paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/custom_ip_regbank.sv
// APB3-slave register bank for the custom IP register interface.
// Software writes to WR_DATA[k] become level req/ack transfers on reg2ip_*;
// a write to a channel whose previous transfer is still pending stalls the bus
// until the IP acknowledges or the wait times out. IP status words are captured
// into RD_DATA[k] with sticky valid flags that a read clears.
//
//  state    | meaning
//  IDLE     | no transfer in progress, waiting for an APB setup phase
//  ACCESS   | APB access phase; pready/pslverr already registered for it
//  WAIT_ACK | write stalled behind a pending transfer, counting towards timeout
module custom_ip_regbank #(
  parameter int N_WR    = 3,
  parameter int N_RD    = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  custom_ip_regbank_if.slave   apb,
  output logic [N_WR*DW-1:0]   reg2ip_data,
  output logic [N_WR-1:0]      reg2ip_en,
  input  logic [N_WR-1:0]      reg2ip_ack,
  input  logic [N_RD*DW-1:0]   ip2reg_data,
  input  logic [N_RD-1:0]      ip2reg_en
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_ACK} state_t;

  state_t          state;
  logic            pready_q;
  logic            pslverr_q;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   wr_q [N_WR];
  logic [DW-1:0]   rd_q [N_RD];
  logic [N_RD-1:0] valid_q;

  logic [3:0]      idx;
  logic            is_wr;
  logic            is_rd;
  logic            is_st;
  logic            dec_err;
  logic            pend_hit;
  logic            ack_hit;
  logic            commit;
  logic            wr_commit;
  logic            rd_commit;
  logic [31:0]     rdata;
  logic            unused_bits;

  // Byte-address bits [1:0] are ignored and narrow channels drop upper write data.
  assign unused_bits = ^{apb.paddr_i[1:0], apb.pwdata_i};

  // Address decode of the current APB address, plus pending/ack of the addressed write channel.
  always_comb begin
    idx      = apb.paddr_i[5:2];
    is_wr    = 1'b0;
    is_rd    = 1'b0;
    pend_hit = 1'b0;
    ack_hit  = 1'b0;
    for (int k = 0; k < N_WR; k++) begin
      if (apb.paddr_i[7:6] == 2'b00 && idx == 4'(k)) begin
        is_wr    = 1'b1;
        pend_hit = reg2ip_en[k];
        ack_hit  = reg2ip_ack[k];
      end
    end
    for (int k = 0; k < N_RD; k++) begin
      if (apb.paddr_i[7:6] == 2'b01 && idx == 4'(k)) begin
        is_rd = 1'b1;
      end
    end
    is_st   = (apb.paddr_i[7:2] == 6'h20);
    dec_err = apb.pwrite_i ? !is_wr : !(is_wr || is_rd || is_st);
  end

  // Bus phase sequencing; pready/pslverr are decided one edge ahead so they are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (apb.psel_i && !apb.penable_i) begin
            state <= ACCESS;
            cnt   <= '0;
            if (apb.pwrite_i && is_wr && pend_hit) begin
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
            end else begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err;
            end
          end
        end
        ACCESS: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          cnt       <= '0;
          state     <= pready_q ? IDLE : WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack retiring the old transfer (or one that already retired) lets the new write in.
          if (ack_hit || !pend_hit) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            state     <= ACCESS;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            state     <= ACCESS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  // A transfer takes effect only on its error-free completing edge.
  assign commit    = (state == ACCESS) && pready_q && !pslverr_q;
  assign wr_commit = commit && apb.pwrite_i;
  assign rd_commit = commit && !apb.pwrite_i;

  // Write channels: accepted data is driven to the IP and held with en until acked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_WR; k++) begin
        wr_q[k] <= '0;
      end
      reg2ip_en <= '0;
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (wr_commit && is_wr && idx == 4'(k)) begin
          wr_q[k]      <= apb.pwdata_i[DW-1:0];
          reg2ip_en[k] <= 1'b1;
        end else if (reg2ip_ack[k]) begin
          reg2ip_en[k] <= 1'b0;
        end
      end
    end
  end

  // Read channels: a capture strobe always wins over the valid-clear of a coincident read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_RD; k++) begin
        rd_q[k] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        if (ip2reg_en[k]) begin
          rd_q[k]    <= ip2reg_data[k*DW +: DW];
          valid_q[k] <= 1'b1;
        end else if (rd_commit && is_rd && idx == 4'(k)) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Read data is presented only in a successful read completion cycle, zero-extended.
  always_comb begin
    rdata = '0;
    if (rd_commit) begin
      if (is_st) begin
        rdata[N_WR-1:0]   = reg2ip_en;
        rdata[16 +: N_RD] = valid_q;
      end
      for (int k = 0; k < N_WR; k++) begin
        if (is_wr && idx == 4'(k)) begin
          rdata[DW-1:0] = wr_q[k];
        end
      end
      for (int k = 0; k < N_RD; k++) begin
        if (is_rd && idx == 4'(k)) begin
          rdata[DW-1:0] = rd_q[k];
        end
      end
    end
  end

  for (genvar g = 0; g < N_WR; g++) begin : g_wr_out
    assign reg2ip_data[g*DW +: DW] = wr_q[g];
  end

  assign apb.prdata_o  = rdata;
  assign apb.pready_o  = pready_q;
  assign apb.pslverr_o = pslverr_q;

endmodule

// File: tb/tb_custom_ip_regbank.sv
// Self-checking bench for custom_ip_regbank: error-map vector table, directed
// stall/timeout/capture sequences, and a randomized run against a register-map model.
module tb_custom_ip_regbank;
  localparam int N_WR    = 3;
  localparam int N_RD    = 3;
  localparam int DW      = 32;
  localparam int TIMEOUT = 256;
  localparam int BOUND   = TIMEOUT + 32;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N_WR*DW-1:0]   reg2ip_data;
  logic [N_WR-1:0]      reg2ip_en;
  logic [N_WR-1:0]      reg2ip_ack;
  logic [N_RD*DW-1:0]   ip2reg_data;
  logic [N_RD-1:0]      ip2reg_en;

  custom_ip_regbank_if bus ();

  custom_ip_regbank #(.N_WR(N_WR), .N_RD(N_RD), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .apb         (bus),
    .reg2ip_data (reg2ip_data),
    .reg2ip_en   (reg2ip_en),
    .reg2ip_ack  (reg2ip_ack),
    .ip2reg_data (ip2reg_data),
    .ip2reg_en   (ip2reg_en)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] rd;
  logic        err;
  int          waits;

  // reference model of the register map
  logic [DW-1:0]   wr_m [N_WR];
  logic [DW-1:0]   rd_m [N_RD];
  logic [N_RD-1:0] valid_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] rdo, output logic erro, output int w);
    @(posedge clk_i); #1;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
    bus.paddr_i = a; bus.pwdata_i = wd;
    @(posedge clk_i); #1;
    bus.penable_i = 1'b1;
    w = 0;
    while (bus.pready_o !== 1'b1 && w < BOUND) begin
      @(posedge clk_i); #1;
      w++;
    end
    rdo  = bus.prdata_o;
    erro = bus.pslverr_o;
    if (bus.pready_o !== 1'b1) begin
      n_total++;
      $display("FAIL apb_pready: no pready within %0d cycles at addr 0x%02h", BOUND, a);
    end
    @(posedge clk_i); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
  endtask

  task automatic ack_pulse(input int k);
    reg2ip_ack[k] = 1'b1;
    @(posedge clk_i); #1;
    reg2ip_ack[k] = 1'b0;
  endtask

  task automatic capture(input int k, input logic [DW-1:0] d);
    ip2reg_data[k*DW +: DW] = d;
    ip2reg_en[k] = 1'b1;
    @(posedge clk_i); #1;
    ip2reg_en[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int k = 0; k < N_WR; k++) wr_m[k] = '0;
    for (int k = 0; k < N_RD; k++) rd_m[k] = '0;
    valid_m = '0;
  endtask

  initial begin
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.paddr_i = '0; bus.pwdata_i = '0;
    reg2ip_ack = '0; ip2reg_en = '0; ip2reg_data = '0;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pready", 32'(bus.pready_o), 32'd0);
    chk("rst_pslverr", 32'(bus.pslverr_o), 32'd0);
    chk("rst_prdata", bus.prdata_o, 32'd0);
    chk("rst_en", 32'(reg2ip_en), 32'd0);
    chk("rst_data0", reg2ip_data[31:0], 32'd0);
    do_reset();

    // table: reset reads and error addresses (no side effects)
    vecs.push_back('{0, 8'h80, 32'h0,        32'h0, 0});
    vecs.push_back('{0, 8'h40, 32'h0,        32'h0, 0});
    vecs.push_back('{0, 8'h00, 32'h0,        32'h0, 0});
    vecs.push_back('{0, 8'hFC, 32'h0,        32'h0, 1});
    vecs.push_back('{1, 8'h40, 32'hDEADBEEF, 32'h0, 1});
    vecs.push_back('{1, 8'h80, 32'h12345678, 32'h0, 1});
    vecs.push_back('{0, 8'h4C, 32'h0,        32'h0, 1});
    vecs.push_back('{1, 8'h0C, 32'h55,       32'h0, 1});
    vecs.push_back('{0, 8'h84, 32'h0,        32'h0, 1});
    vecs.push_back('{0, 8'h81, 32'h0,        32'h0, 0});
    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, waits);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    chk("vec_no_side_en", 32'(reg2ip_en), 32'd0);

    // single write to channel 1, then ack
    apb(1, 8'h04, 32'hA5, rd, err, waits);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_waits", 32'(waits), 32'd0);
    chk("t2_en", 32'(reg2ip_en), 32'h2);
    chk("t2_data1", reg2ip_data[63:32], 32'hA5);
    apb(0, 8'h80, 32'h0, rd, err, waits);
    chk("t2_status", rd, 32'h2);
    ack_pulse(1);
    chk("t2_en_drop", 32'(reg2ip_en), 32'h0);
    apb(0, 8'h80, 32'h0, rd, err, waits);
    chk("t2_status_clr", rd, 32'h0);

    // second write stalls behind the first until ack
    apb(1, 8'h00, 32'h11, rd, err, waits);
    chk("t3_data_first", reg2ip_data[31:0], 32'h11);
    fork
      apb(1, 8'h00, 32'h22, rd, err, waits);
      begin
        repeat (12) @(posedge clk_i);
        #1;
        ack_pulse(0);
      end
    join
    chk("t3_err", 32'(err), 32'd0);
    chk_rng("t3_stall", waits, 5, 20);
    chk("t3_data", reg2ip_data[31:0], 32'h22);
    chk("t3_en", 32'(reg2ip_en), 32'h1);
    ack_pulse(0);

    // stalled write with no ack times out and is dropped
    apb(1, 8'h00, 32'h11, rd, err, waits);
    apb(1, 8'h00, 32'h33, rd, err, waits);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_rdata", rd, 32'h0);
    chk_rng("t4_stall", waits, TIMEOUT - 1, TIMEOUT + 2);
    chk("t4_data", reg2ip_data[31:0], 32'h11);
    chk("t4_en", 32'(reg2ip_en), 32'h1);
    ack_pulse(0);

    // capture, read-clears-valid, capture coincident with read
    capture(2, 32'h48D0);
    apb(0, 8'h80, 32'h0, rd, err, waits);
    chk("t5_status_set", rd, 32'h0004_0000);
    apb(0, 8'h48, 32'h0, rd, err, waits);
    chk("t5_rd", rd, 32'h48D0);
    apb(0, 8'h80, 32'h0, rd, err, waits);
    chk("t5_status_clr", rd, 32'h0);
    capture(2, 32'h48D0);
    fork
      apb(0, 8'h48, 32'h0, rd, err, waits);
      begin
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        ip2reg_data[2*DW +: DW] = 32'h1234;
        ip2reg_en[2] = 1'b1;
        @(posedge clk_i);
        #1;
        ip2reg_en[2] = 1'b0;
      end
    join
    chk("t5_coinc_old", rd, 32'h48D0);
    apb(0, 8'h80, 32'h0, rd, err, waits);
    chk("t5_coinc_valid", rd, 32'h0004_0000);
    apb(0, 8'h48, 32'h0, rd, err, waits);
    chk("t5_coinc_new", rd, 32'h1234);

    // async reset in the middle of a stalled write
    apb(1, 8'h08, 32'h77, rd, err, waits);
    fork
      apb(1, 8'h08, 32'h78, rd, err, waits);
      begin
        repeat (5) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_en", 32'(reg2ip_en), 32'h0);
        chk("rst_mid_pready", 32'(bus.pready_o), 32'h0);
        #2;
        rst_ni = 1'b1;
        n_total++;
        if (bus.pready_o === 1'b0) n_pass++;
        else $display("FAIL rst_mid_hold: pready %b expected 0", bus.pready_o);
        // release the stalled bench transfer by timing out is not wanted; end it via a bus idle
        force_idle();
      end
    join_any
    disable fork;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    do_reset();

    // randomized run against the register-map model
    for (int it = 0; it < 300; it++) begin
      int          op;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_err;
      bit          in_wr, in_rd, in_st;
      int          k;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        logic [N_RD-1:0] mask;
        mask = N_RD'($urandom_range(1, (1 << N_RD) - 1));
        for (int c = 0; c < N_RD; c++) begin
          if (mask[c]) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            ip2reg_data[c*DW +: DW] = d;
            rd_m[c] = d;
            valid_m[c] = 1'b1;
          end
        end
        ip2reg_en = mask;
        @(posedge clk_i); #1;
        ip2reg_en = '0;
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 8'(4 * $urandom_range(0, 4));
          1:       a = 8'h40 + 8'(4 * $urandom_range(0, 4));
          2:       a = 8'h80;
          default: a = 8'($urandom_range(0, 255));
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        wd = $urandom;
        k = int'(a[5:2]);
        in_wr = (a < 8'h40) && (k < N_WR);
        in_rd = (a >= 8'h40) && (a < 8'h80) && (k < N_RD);
        in_st = (a >= 8'h80) && (a < 8'h84);
        exp_err = (op == 1) ? !in_wr : !(in_wr || in_rd || in_st);
        exp_rd = 32'h0;
        if (op == 2 && !exp_err) begin
          if (in_wr) exp_rd = 32'(wr_m[k]);
          else if (in_rd) exp_rd = 32'(rd_m[k]);
          else exp_rd = 32'(valid_m) << 16;
        end
        apb(op == 1, a, wd, rd, err, waits);
        chk($sformatf("rnd%0d_err_a%02h", it, a), 32'(err), 32'(exp_err));
        chk($sformatf("rnd%0d_rd_a%02h", it, a), rd, exp_rd);
        if (op == 1 && !exp_err) begin
          wr_m[k] = wd[DW-1:0];
          chk($sformatf("rnd%0d_en", it), 32'(reg2ip_en), 32'(1) << k);
          chk($sformatf("rnd%0d_data", it), 32'(reg2ip_data[k*DW +: DW]), 32'(wr_m[k]));
          ack_pulse(k);
          chk($sformatf("rnd%0d_en_drop", it), 32'(reg2ip_en), 32'h0);
        end
        if (op == 2 && !exp_err && in_rd) valid_m[k] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic force_idle();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

endmodule
